icache_dm: RTL and testbench
============================

// Module: icache_dm
// PURPOSE
// Direct-mapped, read-only instruction cache sitting directly upstream of the fetch stage.
// - Serves the fetch stage's PC request with a same-cycle hit response (instr_o, ready_o).
// - On a miss, refills one line word-by-word from main memory.
// - Snoops data-side stores and invalidates stale lines, so self-modifying code is never served stale words.
// PARAMETERS
// NUM_SETS        16   number of lines (power of 2, >=2)
// WORDS_PER_LINE  4    32-bit words per line (power of 2, >=2)
// RESET_PC        32'hbfc00000  informational only; no preload
// PORTS
// clk_i           in   1   clock, all state on rising edge
// rst_ni          in   1   asynchronous active-low reset
// addr_i          in   32  fetch address (PC) from fetch stage
// validReq_i      in   1   fetch stage requests addr_i this cycle
// instr_o         out  32  instruction word for addr_i; valid only when ready_o=1
// ready_o         out  1   hit: instr_o valid this cycle (combinational)
// mem_req_o       out  1   refill beat request to main memory
// mem_addr_o      out  32  word address of current refill beat
// mem_rdata_i     in   32  refill data
// mem_valid_i     in   1   mem_rdata_i valid; completes current beat
// snoop_we_i      in   1   data-side store committing this cycle
// snoop_addr_i    in   32  store address
// invalidate_i    in   1   fence.i: invalidate whole cache
// BEHAVIOUR
// Address split (defaults): [1:0] ignored; word [3:2]; index [7:4]; tag [31:8].
//   Widths scale with log2(WORDS_PER_LINE) and log2(NUM_SETS).
// Storage: valid[NUM_SETS], tag[NUM_SETS], data[NUM_SETS][WORDS_PER_LINE] in flops; async read.
// Reset (async, rst_ni=0):
//   - all valid bits 0; state IDLE; beat counter 0; poison flag 0.
//   - mem_req_o=0, ready_o=0, mem_addr_o=0; instr_o=0 while ready_o=0.
//   - Reset during REFILL aborts it; the line stays invalid.
// FSM IDLE:
//   - hit = validReq_i & valid[idx] & tag match & no snoop/invalidate on that line this cycle.
//   - ready_o=hit; instr_o=data[idx][word] (0 when not hit).
//   - On miss: latch line base (addr_i with word+offset zeroed) and go to REFILL next cycle.
// FSM REFILL:
//   - mem_req_o=1, mem_addr_o = base + 4*beat, held stable until mem_valid_i.
//   - Each mem_valid_i writes data[idx][beat] and increments beat.
//   - valid[idx] is cleared on entry to REFILL.
//   - Last beat (beat=WORDS_PER_LINE-1): write tag; set valid unless poisoned; beat->0; -> IDLE.
//   - ready_o=0 throughout. addr_i/validReq_i changes are ignored and the refill always completes.
// Miss penalty: 1 + sum of beat latencies; earliest hit is the cycle after the last mem_valid_i.
// Snoop: snoop_we_i & valid line matching snoop_addr_i index+tag clears that valid next edge.
//   - Same-cycle snoop on the requested line suppresses ready_o.
//   - Snoop matching the line under refill (base match) sets poison; the line finishes invalid.
// invalidate_i: clears all valid bits at the next edge and suppresses ready_o that cycle.
//   - During REFILL it sets poison.
// Simultaneous last beat + snoop/invalidate on the same line: poison wins; valid stays 0.
// Poison clears on return to IDLE. mem_valid_i outside REFILL is ignored.
// TESTING
// 1. Cold miss: reset, validReq_i=1, addr_i=0xbfc00004, mem latency 2/beat.
//    -> mem_addr_o 0xbfc00000,04,08,0c; ready_o=1 with word1 exactly 1 cycle after 4th mem_valid_i.
// 2. Hit stream: after test 1, addr_i 0xbfc00000..0c on consecutive cycles
//    -> ready_o=1 every cycle, mem_req_o=0, correct words.
// 3. Conflict: fetch 0xbfc00000 then 0xbfc00100 (same index) then 0xbfc00000 -> three refills, last data correct.
// 4. Snoop: cached line 0xbfc00000; snoop_we_i=1, snoop_addr_i=0xbfc00008 with validReq_i on 0xbfc00000
//    -> ready_o=0 that cycle, next fetch refills with new memory data.
// 5. Poison: invalidate_i pulsed on beat 2 of a refill -> refill completes (4 beats),
//    line invalid, refetch triggers a second refill.
// 6. Reset mid-refill: rst_ni=0 during beat 1 -> mem_req_o=0 immediately;
//    after release the same address misses again from beat 0.

Source files
------------

// File: rtl/icache_dm.sv
// icache_dm: direct-mapped read-only instruction cache.
// Same-cycle hits, word-serial refill, store snoop and fence.i invalidation.
module icache_dm #(
   parameter int unsigned NUM_SETS       = 16,
   parameter int unsigned WORDS_PER_LINE = 4,
   parameter logic [31:0] RESET_PC       = 32'hbfc00000
) (
   input  logic        clk_i,
   input  logic        rst_ni,
   input  logic [31:0] addr_i,
   input  logic        validReq_i,
   output logic [31:0] instr_o,
   output logic        ready_o,
   output logic        mem_req_o,
   output logic [31:0] mem_addr_o,
   input  logic [31:0] mem_rdata_i,
   input  logic        mem_valid_i,
   input  logic        snoop_we_i,
   input  logic [31:0] snoop_addr_i,
   input  logic        invalidate_i
);

   localparam int unsigned WB = $clog2(WORDS_PER_LINE);
   localparam int unsigned IB = $clog2(NUM_SETS);
   localparam int unsigned TW = 30 - WB - IB;

   typedef enum logic {
      IDLE,
      REFILL
   } state_e;

   state_e           state_q, state_d;
   logic [WB-1:0]    beat_q, beat_d;
   logic             poison_q, poison_d;
   logic [TW-1:0]    rtag_q, rtag_d;
   logic [IB-1:0]    ridx_q, ridx_d;

   logic [NUM_SETS-1:0] valid_q, valid_d;
   logic [TW-1:0]       tag_q  [NUM_SETS];
   logic [31:0]         data_q [NUM_SETS][WORDS_PER_LINE];

   logic [WB-1:0] req_word;
   logic [IB-1:0] req_idx;
   logic [TW-1:0] req_tag;
   logic [IB-1:0] snp_idx;
   logic [TW-1:0] snp_tag;

   logic is_idle;
   logic line_hit;
   logic snp_req;
   logic snp_ref;
   logic snp_hit;
   logic hit;
   logic miss;
   logic beat_wr;
   logic last_beat;
   logic kill;
   logic unused_ok;

   // Address split and lookup terms
   always_comb begin
      req_word  = addr_i[2 +: WB];
      req_idx   = addr_i[2 + WB +: IB];
      req_tag   = addr_i[31 -: TW];
      snp_idx   = snoop_addr_i[2 + WB +: IB];
      snp_tag   = snoop_addr_i[31 -: TW];
      is_idle   = (state_q == IDLE);
      line_hit  = valid_q[req_idx] && (tag_q[req_idx] == req_tag);
      snp_req   = snoop_we_i && (snp_idx == req_idx) && (snp_tag == req_tag);
      snp_ref   = snoop_we_i && (snp_idx == ridx_q) && (snp_tag == rtag_q);
      snp_hit   = snoop_we_i && valid_q[snp_idx] && (tag_q[snp_idx] == snp_tag);
      hit       = validReq_i && line_hit && !snp_req && !invalidate_i;
      miss      = is_idle && validReq_i && !hit;
      beat_wr   = !is_idle && mem_valid_i;
      last_beat = (beat_q == WB'(WORDS_PER_LINE - 1));
      kill      = poison_q || invalidate_i || snp_ref;
   end

   // Fetch-side and memory-side outputs
   always_comb begin
      ready_o    = is_idle && hit;
      instr_o    = ready_o ? data_q[req_idx][req_word] : 32'h0;
      mem_req_o  = !is_idle;
      mem_addr_o = is_idle ? 32'h0 : {rtag_q, ridx_q, beat_q, 2'b00};
   end

   // Refill sequencer next state
   always_comb begin
      state_d  = state_q;
      beat_d   = beat_q;
      poison_d = poison_q;
      rtag_d   = rtag_q;
      ridx_d   = ridx_q;
      unique case (state_q)
         IDLE: begin
            if (miss) begin
               state_d  = REFILL;
               beat_d   = '0;
               poison_d = 1'b0;
               rtag_d   = req_tag;
               ridx_d   = req_idx;
            end
         end
         REFILL: begin
            if (invalidate_i || snp_ref) begin
               poison_d = 1'b1;
            end
            if (mem_valid_i) begin
               if (last_beat) begin
                  state_d  = IDLE;
                  beat_d   = '0;
                  poison_d = 1'b0;
               end else begin
                  beat_d = beat_q + WB'(1);
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // Refill sequencer registers
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q  <= IDLE;
         beat_q   <= '0;
         poison_q <= 1'b0;
         rtag_q   <= '0;
         ridx_q   <= '0;
      end else begin
         state_q  <= state_d;
         beat_q   <= beat_d;
         poison_q <= poison_d;
         rtag_q   <= rtag_d;
         ridx_q   <= ridx_d;
      end
   end

   // Line valid bits: snoop/fence clear, miss clears, clean refill sets
   always_comb begin
      valid_d = valid_q;
      if (snp_hit) begin
         valid_d[snp_idx] = 1'b0;
      end
      if (invalidate_i) begin
         valid_d = '0;
      end
      if (miss) begin
         valid_d[req_idx] = 1'b0;
      end
      if (beat_wr && last_beat && !kill) begin
         valid_d[ridx_q] = 1'b1;
      end
   end

   // Valid bit storage
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         valid_q <= '0;
      end else begin
         valid_q <= valid_d;
      end
   end

   // Tag and data storage, written by refill beats
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         for (int s = 0; s < int'(NUM_SETS); s++) begin
            tag_q[s] <= '0;
            for (int w = 0; w < int'(WORDS_PER_LINE); w++) begin
               data_q[s][w] <= '0;
            end
         end
      end else if (beat_wr) begin
         data_q[ridx_q][beat_q] <= mem_rdata_i;
         if (last_beat) begin
            tag_q[ridx_q] <= rtag_q;
         end
      end
   end

   assign unused_ok = ^{addr_i[1:0], snoop_addr_i[1 + WB:0], RESET_PC};

endmodule

// File: tb/tb_icache_dm.sv
// tb_icache_dm: random and directed fetches against a line-level cache model.
// Memory responder and store snoops are driven from the bench.
module tb_icache_dm;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [31:0] addr;
   logic        vreq;
   logic [31:0] instr;
   logic        ready;
   logic        mem_req;
   logic [31:0] mem_addr;
   logic [31:0] mem_rdata;
   logic        mem_valid;
   logic        snoop_we;
   logic [31:0] snoop_addr;
   logic        inv_i;

   int n_chk = 0;
   int n_err = 0;

   logic [31:0] mem [logic [29:0]];
   bit          m_valid [16];
   logic [23:0] m_tag   [16];
   logic [31:0] m_data  [16][4];

   icache_dm dut (
      .clk_i        (clk),
      .rst_ni       (rst_n),
      .addr_i       (addr),
      .validReq_i   (vreq),
      .instr_o      (instr),
      .ready_o      (ready),
      .mem_req_o    (mem_req),
      .mem_addr_o   (mem_addr),
      .mem_rdata_i  (mem_rdata),
      .mem_valid_i  (mem_valid),
      .snoop_we_i   (snoop_we),
      .snoop_addr_i (snoop_addr),
      .invalidate_i (inv_i)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got,
                      input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   function automatic logic [31:0] mem_rd(input logic [31:0] a);
      logic [29:0] k;
      k = a[31:2];
      if (mem.exists(k)) return mem[k];
      return ({2'b00, k} * 32'h9e3779b1) ^ 32'h0badf00d;
   endfunction

   function automatic logic [31:0] rnd_addr();
      logic [23:0] t;
      case ($urandom_range(0, 2))
         0: t = 24'hbfc000;
         1: t = 24'hbfc001;
         default: t = 24'h000123;
      endcase
      return {t, 2'b00, 2'($urandom_range(0, 3)),
              2'($urandom_range(0, 3)), 2'b00};
   endfunction

   // model effect of a committing store and/or fence.i
   task automatic apply_ev(input bit s, input logic [31:0] sa, input bit inv);
      int i;
      if (s) begin
         mem[sa[31:2]] = $urandom;
         i = int'(sa[7:4]);
         if (m_valid[i] && m_tag[i] == sa[31:8]) m_valid[i] = 0;
      end
      if (inv) begin
         for (int j = 0; j < 16; j++) m_valid[j] = 0;
      end
   endtask

   // one fetch: hit check, or full refill with optional in-refill event
   // ev_kind: 1 store snoop at ev_a, 2 fence.i, 3 reset
   task automatic fetch(input logic [31:0] a, input int lat, input bit jv,
                        input bit s_en, input logic [31:0] s_a,
                        input bit inv, input int ev_beat,
                        input int ev_kind, input logic [31:0] ev_a);
      logic [31:0] base;
      logic [31:0] exp_a;
      logic [31:0] line [4];
      int idx;
      int w;
      bit hit;
      bit poison;
      base   = {a[31:4], 4'h0};
      idx    = int'(a[7:4]);
      w      = int'(a[3:2]);
      poison = 0;
      @(negedge clk);
      addr       = a;
      vreq       = 1'b1;
      snoop_we   = s_en;
      snoop_addr = s_a;
      inv_i      = inv;
      mem_valid  = jv;
      mem_rdata  = $urandom;
      hit = m_valid[idx] && (m_tag[idx] == a[31:8]) && !inv &&
            !(s_en && s_a[31:4] == a[31:4]);
      #1;
      chk("ready", 32'(ready), 32'(hit));
      chk("instr", instr, hit ? m_data[idx][w] : 32'h0);
      chk("mem_req_idle", 32'(mem_req), 32'h0);
      apply_ev(s_en, s_a, inv);
      if (hit) return;
      m_valid[idx] = 0;
      for (int b = 0; b < 4; b++) begin
         for (int k = 0; k < lat; k++) begin
            @(negedge clk);
            snoop_we = 1'b0;
            inv_i    = 1'b0;
            addr     = rnd_addr();
            vreq     = 1'($urandom_range(0, 1));
            if (b == ev_beat && k == 0) begin
               if (ev_kind == 3) begin
                  rst_n     = 1'b0;
                  mem_valid = 1'b0;
                  #1;
                  chk("rst_mem_req", 32'(mem_req), 32'h0);
                  chk("rst_mem_addr", mem_addr, 32'h0);
                  chk("rst_ready", 32'(ready), 32'h0);
                  chk("rst_instr", instr, 32'h0);
                  for (int j = 0; j < 16; j++) m_valid[j] = 0;
                  @(negedge clk);
                  vreq  = 1'b0;
                  rst_n = 1'b1;
                  return;
               end
               if (ev_kind == 1) begin
                  snoop_we   = 1'b1;
                  snoop_addr = ev_a;
                  if (ev_a[31:4] == a[31:4]) poison = 1;
               end
               if (ev_kind == 2) begin
                  inv_i  = 1'b1;
                  poison = 1;
               end
            end
            exp_a     = base + 32'(4 * b);
            mem_valid = (k == lat - 1);
            mem_rdata = mem_valid ? mem_rd(exp_a) : $urandom;
            if (mem_valid) line[b] = mem_rdata;
            #1;
            chk("mem_req", 32'(mem_req), 32'h1);
            chk("mem_addr", mem_addr, exp_a);
            chk("ready_refill", 32'(ready), 32'h0);
            apply_ev(snoop_we, snoop_addr, inv_i);
         end
      end
      @(negedge clk);
      mem_valid = 1'b0;
      snoop_we  = 1'b0;
      inv_i     = 1'b0;
      addr      = a;
      vreq      = !poison;
      if (!poison) begin
         m_valid[idx] = 1;
         m_tag[idx]   = a[31:8];
         for (int j = 0; j < 4; j++) m_data[idx][j] = line[j];
      end
      #1;
      chk("ready_done", 32'(ready), 32'(!poison));
      chk("instr_done", instr, poison ? 32'h0 : line[w]);
      chk("mem_req_done", 32'(mem_req), 32'h0);
   endtask

   initial begin
      logic [31:0] ra;
      logic [31:0] sa;
      logic [31:0] ea;
      int kind;
      rst_n      = 1'b0;
      addr       = 32'hbfc00004;
      vreq       = 1'b1;
      mem_rdata  = 32'h0;
      mem_valid  = 1'b1;
      snoop_we   = 1'b0;
      snoop_addr = 32'h0;
      inv_i      = 1'b0;
      for (int j = 0; j < 16; j++) m_valid[j] = 0;

      repeat (2) @(negedge clk);
      #1;
      chk("reset_ready", 32'(ready), 32'h0);
      chk("reset_instr", instr, 32'h0);
      chk("reset_mem_req", 32'(mem_req), 32'h0);
      chk("reset_mem_addr", mem_addr, 32'h0);
      vreq      = 1'b0;
      mem_valid = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;

      // cold miss, latency 2 per beat
      fetch(32'hbfc00004, 2, 0, 0, 0, 0, -1, 0, 0);
      // hit stream over the same line
      for (int i = 0; i < 4; i++) begin
         fetch(32'hbfc00000 + 32'(4 * i), 1, 0, 0, 0, 0, -1, 0, 0);
      end
      // conflict on index 0
      fetch(32'hbfc00000, 1, 0, 0, 0, 0, -1, 0, 0);
      fetch(32'hbfc00100, 3, 0, 0, 0, 0, -1, 0, 0);
      fetch(32'hbfc00000, 1, 0, 0, 0, 0, -1, 0, 0);
      // same-cycle snoop on the requested line
      fetch(32'hbfc00000, 1, 0, 1, 32'hbfc00008, 0, -1, 0, 0);
      fetch(32'hbfc00008, 1, 0, 0, 0, 0, -1, 0, 0);
      // fence.i during beat 2 poisons the refill
      fetch(32'hbfc00020, 2, 0, 0, 0, 0, 2, 2, 0);
      fetch(32'hbfc00020, 1, 0, 0, 0, 0, -1, 0, 0);
      // reset during beat 1
      fetch(32'hbfc00030, 2, 0, 0, 0, 0, 1, 3, 0);
      fetch(32'hbfc00030, 1, 0, 0, 0, 0, -1, 0, 0);

      for (int i = 0; i < 300; i++) begin
         ra   = rnd_addr();
         sa   = rnd_addr();
         kind = 0;
         ea   = 32'h0;
         if ($urandom_range(0, 4) == 0) begin
            kind = $urandom_range(1, 2);
            ea   = $urandom_range(0, 1) ? {ra[31:4], 2'($urandom_range(0, 3)), 2'b00}
                                        : rnd_addr();
         end
         fetch(ra, $urandom_range(1, 3), 1'($urandom_range(0, 1)),
               ($urandom_range(0, 9) == 0), sa, ($urandom_range(0, 19) == 0),
               $urandom_range(0, 3), kind, ea);
      end

      @(negedge clk);
      vreq      = 1'b0;
      mem_valid = 1'b0;
      $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
      $finish;
   end

endmodule
